// File: rtl/smoldvi_pattern_gen.sv
// smoldvi_pattern_gen: test-pattern pixel source for the smoldvi encoder.
// Walks an (x, y) raster in the clk_pix domain. It presents one registered
// RGB888 pixel and advances only when the sink accepts it through rgb_rdy.
module smoldvi_pattern_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned X_STEP   = 2
) (
    input  logic       clk_pix,
    input  logic       rst_pix,
    input  logic [1:0] pattern_sel,
    input  logic       rgb_rdy,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic [7:0] frame_ctr,
    output logic       sof
);

    typedef enum logic [1:0] {
        PAT_GRADIENT = 2'd0,
        PAT_BARS     = 2'd1,
        PAT_CHECKER  = 2'd2,
        PAT_XOR      = 2'd3
    } pattern_t;

    localparam logic [9:0]  X_LAST = 10'(H_ACTIVE - X_STEP);
    localparam logic [8:0]  Y_LAST = 9'(V_ACTIVE - 1);
    localparam logic [9:0]  X_INC  = 10'(X_STEP);
    localparam int unsigned BAR_W  = H_ACTIVE / 8;

    logic [9:0] r_x;
    logic [8:0] r_y;
    logic [7:0] r_frame;
    pattern_t   r_pat;
    logic [7:0] r_r;
    logic [7:0] r_g;
    logic [7:0] r_b;

    logic [9:0] w_x_nxt;
    logic [8:0] w_y_nxt;
    logic [7:0] w_frame_nxt;
    pattern_t   w_pat_nxt;
    logic [2:0] w_bar_idx;
    logic [7:0] w_xy;
    logic       w_chk;
    logic [7:0] w_r_nxt;
    logic [7:0] w_g_nxt;
    logic [7:0] w_b_nxt;

    // Raster position that follows the presented pixel. The pattern and frame count update at frame wrap.
    always_comb begin
        w_x_nxt     = r_x + X_INC;
        w_y_nxt     = r_y;
        w_frame_nxt = r_frame;
        w_pat_nxt   = r_pat;
        if (r_x == X_LAST) begin
            w_x_nxt = '0;
            if (r_y == Y_LAST) begin
                w_y_nxt     = '0;
                w_frame_nxt = r_frame + 8'd1;
                w_pat_nxt   = pattern_t'(pattern_sel);
            end else begin
                w_y_nxt = r_y + 9'd1;
            end
        end
    end

    // Colour-bar index from constant boundary compares. The last boundary passed wins, so x == k*BAR_W lands in bar k.
    always_comb begin
        w_bar_idx = '0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (w_x_nxt >= 10'(k * BAR_W)) begin
                w_bar_idx = 3'(k);
            end
        end
    end

    // Pattern function, evaluated on the post-wrap coordinates so a new frame starts with its own pattern and count.
    always_comb begin
        w_xy    = w_x_nxt[7:0] ^ w_y_nxt[7:0];
        w_chk   = w_x_nxt[5] ^ w_y_nxt[5] ^ w_frame_nxt[0];
        w_r_nxt = '0;
        w_g_nxt = '0;
        w_b_nxt = '0;
        case (w_pat_nxt)
            PAT_GRADIENT: begin
                w_r_nxt = w_x_nxt[7:0] + w_frame_nxt;
                w_g_nxt = w_y_nxt[7:0] + {w_frame_nxt[6:0], 1'b0};
                w_b_nxt = w_frame_nxt;
            end
            PAT_BARS: begin
                w_r_nxt = {8{w_bar_idx[2]}};
                w_g_nxt = {8{w_bar_idx[1]}};
                w_b_nxt = {8{w_bar_idx[0]}};
            end
            PAT_CHECKER: begin
                w_r_nxt = {8{w_chk}};
                w_g_nxt = {8{w_chk}};
                w_b_nxt = {8{w_chk}};
            end
            PAT_XOR: begin
                w_r_nxt = w_xy;
                w_g_nxt = w_xy + w_frame_nxt;
                w_b_nxt = ~w_xy;
            end
            default: begin
                w_r_nxt = '0;
                w_g_nxt = '0;
                w_b_nxt = '0;
            end
        endcase
    end

    // Advance the raster and load the next pixel only when the sink accepts the current one.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r_x     <= '0;
            r_y     <= '0;
            r_frame <= '0;
            r_pat   <= PAT_GRADIENT;
            r_r     <= '0;
            r_g     <= '0;
            r_b     <= '0;
        end else if (rgb_rdy) begin
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_frame <= w_frame_nxt;
            r_pat   <= w_pat_nxt;
            r_r     <= w_r_nxt;
            r_g     <= w_g_nxt;
            r_b     <= w_b_nxt;
        end
    end

    assign r         = r_r;
    assign g         = r_g;
    assign b         = r_b;
    assign x         = r_x;
    assign y         = r_y;
    assign frame_ctr = r_frame;
    assign sof       = (r_x == '0) && (r_y == '0);

endmodule

// File: tb/tb_smoldvi_pattern_gen.sv
// Bench for smoldvi_pattern_gen. The design is built with a small raster so
// that several frames fit in a short run. Stimulus pushes the expected pixel
// for every accept into a queue. A negedge monitor pops and compares that
// pixel, and also checks that the outputs hold while rgb_rdy is low.
module tb_smoldvi_pattern_gen;

    localparam int H  = 64;
    localparam int V  = 40;
    localparam int XS = 2;

    logic       clk_pix = 1'b0;
    logic       rst_pix;
    logic [1:0] pattern_sel;
    logic       rgb_rdy;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] frame_ctr;
    logic       sof;

    smoldvi_pattern_gen #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .X_STEP   (XS)
    ) dut (
        .clk_pix     (clk_pix),
        .rst_pix     (rst_pix),
        .pattern_sel (pattern_sel),
        .rgb_rdy     (rgb_rdy),
        .r           (r),
        .g           (g),
        .b           (b),
        .x           (x),
        .y           (y),
        .frame_ctr   (frame_ctr),
        .sof         (sof)
    );

    always #5 clk_pix = ~clk_pix;

    typedef struct packed {
        logic [9:0]  x;
        logic [8:0]  y;
        logic [7:0]  f;
        logic        sof;
        logic [23:0] rgb;
    } pix_t;

    pix_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mx = 0, my = 0, mf = 0, mpat = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference pattern function, written directly from the pattern definitions.
    function automatic logic [23:0] model_rgb(input int px, input int py, input int pf, input int pp);
        int idx;
        int t;
        logic [7:0] rr, gg, bb;
        case (pp)
            0: begin
                rr = 8'(px + pf);
                gg = 8'(py + 2 * pf);
                bb = 8'(pf);
            end
            1: begin
                idx = px / (H / 8);
                rr = idx[2] ? 8'hFF : 8'h00;
                gg = idx[1] ? 8'hFF : 8'h00;
                bb = idx[0] ? 8'hFF : 8'h00;
            end
            2: begin
                t  = ((px >> 5) ^ (py >> 5) ^ pf) & 1;
                rr = (t != 0) ? 8'hFF : 8'h00;
                gg = rr;
                bb = rr;
            end
            default: begin
                t  = (px ^ py) & 255;
                rr = 8'(t);
                gg = 8'(t + pf);
                bb = 8'(~t);
            end
        endcase
        return {rr, gg, bb};
    endfunction

    function automatic pix_t model_pix();
        pix_t p;
        p.x   = 10'(mx);
        p.y   = 9'(my);
        p.f   = 8'(mf);
        p.sof = (mx == 0) && (my == 0);
        p.rgb = model_rgb(mx, my, mf, mpat);
        return p;
    endfunction

    // Drive one cycle. An accept pushes the presented pixel and advances the model raster.
    task automatic step(input logic rdy);
        rgb_rdy = rdy;
        if (rdy && !rst_pix) begin
            exp_q.push_back(model_pix());
            if (mx == H - XS) begin
                mx = 0;
                if (my == V - 1) begin
                    my   = 0;
                    mf   = (mf + 1) % 256;
                    mpat = int'(pattern_sel);
                end else begin
                    my++;
                end
            end else begin
                mx += XS;
            end
        end
        @(posedge clk_pix);
        #1;
    endtask

    task automatic run_to(input int tx, input int ty, input int tf, input int duty);
        int i = 0;
        while (!(mx == tx && my == ty && mf == tf) && i < 40000) begin
            step(($urandom_range(99) < duty) ? 1'b1 : 1'b0);
            i++;
        end
        if (i >= 40000) begin
            n_tests++;
            n_fail++;
            $display("FAIL run_to_budget: position (%0d,%0d) frame %0d required, not reached", tx, ty, tf);
        end
    endtask

    task automatic spot(input string nm, input logic [23:0] e_rgb, input int ex, input int ey, input int ef);
        check({nm, "_rgb"}, {r, g, b}, e_rgb);
        check({nm, "_x"}, x, 10'(ex));
        check({nm, "_y"}, y, 9'(ey));
        check({nm, "_frame"}, frame_ctr, 8'(ef));
        check({nm, "_sof"}, sof, (ex == 0) && (ey == 0));
    endtask

    // Monitor: checks each accepted pixel against the scoreboard and checks that the outputs hold while rgb_rdy is low.
    pix_t mon_last;
    logic mon_last_ok = 1'b0;
    always @(negedge clk_pix) begin
        pix_t cur;
        cur = {x, y, frame_ctr, sof, r, g, b};
        if (rst_pix) begin
            mon_last_ok = 1'b0;
        end else begin
            if (mon_last_ok) check("hold_stable", cur, mon_last);
            if (rgb_rdy) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: got pixel %h, expected none outstanding", cur);
                end else begin
                    check("accept_pixel", cur, exp_q.pop_front());
                end
                mon_last_ok = 1'b0;
            end else begin
                mon_last    = cur;
                mon_last_ok = 1'b1;
            end
        end
    end

    initial begin
        rst_pix     = 1'b1;
        rgb_rdy     = 1'b0;
        pattern_sel = 2'd0;
        repeat (3) @(posedge clk_pix);
        #1;
        rst_pix = 1'b0;

        // Reset state held with no accepts.
        repeat (20) step(1'b0);
        spot("reset_idle", 24'h000000, 0, 0, 0);

        // Continuous accept, gradient, through one full frame.
        run_to(0, 0, 1, 100);
        spot("frame1_start", 24'h010201, 0, 0, 1);

        // Sparse accepts over two frames; the scoreboard carries the checks.
        run_to(0, 0, 3, 30);
        spot("frame3_start", 24'h030603, 0, 0, 3);

        // Bars requested mid-frame take effect only at the next frame.
        run_to(0, 20, 3, 100);
        pattern_sel = 2'd1;
        run_to(0, 0, 4, 100);
        spot("bars_x0", 24'h000000, 0, 0, 4);
        run_to(6, 0, 4, 100);
        spot("bars_x6", 24'h000000, 6, 0, 4);
        run_to(8, 0, 4, 100);
        spot("bars_x8", 24'h0000FF, 8, 0, 4);
        run_to(16, 0, 4, 100);
        spot("bars_x16", 24'h00FF00, 16, 0, 4);
        run_to(32, 0, 4, 100);
        spot("bars_x32", 24'hFF0000, 32, 0, 4);
        run_to(56, 0, 4, 100);
        spot("bars_x56", 24'hFFFFFF, 56, 0, 4);
        run_to(62, 0, 4, 100);
        spot("bars_x62", 24'hFFFFFF, 62, 0, 4);

        // Checker: odd frame 5 is inverted, even frame 6 is normal.
        pattern_sel = 2'd2;
        run_to(0, 0, 5, 100);
        spot("chk_f5_0_0", 24'hFFFFFF, 0, 0, 5);
        run_to(32, 0, 5, 100);
        spot("chk_f5_32_0", 24'h000000, 32, 0, 5);
        run_to(32, 32, 5, 100);
        spot("chk_f5_32_32", 24'hFFFFFF, 32, 32, 5);
        run_to(0, 0, 6, 100);
        spot("chk_f6_0_0", 24'h000000, 0, 0, 6);
        run_to(32, 0, 6, 100);
        spot("chk_f6_32_0", 24'hFFFFFF, 32, 0, 6);
        run_to(32, 32, 6, 100);
        spot("chk_f6_32_32", 24'h000000, 32, 32, 6);

        // XOR pattern, then a reset mid-frame while accepting.
        pattern_sel = 2'd3;
        run_to(0, 0, 7, 100);
        spot("xor_f7_0_0", 24'h0007FF, 0, 0, 7);
        run_to(30, 20, 7, 100);
        spot("xor_f7_30_20", 24'h0A11F5, 30, 20, 7);
        rst_pix = 1'b1;
        rgb_rdy = 1'b1;
        #1;
        spot("midreset_now", 24'h000000, 0, 0, 0);
        @(posedge clk_pix);
        #1;
        spot("midreset_next", 24'h000000, 0, 0, 0);
        rgb_rdy = 1'b0;
        rst_pix = 1'b0;
        mx = 0;
        my = 0;
        mf = 0;
        mpat = 0;
        // pattern_sel stays 3; after reset the raster must restart in the gradient pattern.
        run_to(10, 1, 0, 100);
        spot("post_reset_10_1", 24'h0A0100, 10, 1, 0);
        run_to(0, 3, 0, 100);

        step(1'b0);
        @(negedge clk_pix);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
